ddr3_mem_cmd_decoder: RTL and testbench

Memory-side decoder for the controller-to-SDRAM command bus. It samples CS_N/RAS_N/CAS_N/WE_N, BA and A each cpu_clk and tracks the state of every bank. It checks each command against bank state and tRCD/tRP. Legal reads and writes come out as column strobes delayed by CL/CWL, and illegal commands are flagged. It sits on the mem_to_cont side, at the opposite end of the bus from ddr3_mem_cont, and feeds the SDRAM storage array and the bench scoreboard.

---
 rtl/ddr3_mem_cmd_decoder.sv | 247 ++++++++++++++++++++++++
 tb/tb_ddr3_mem_cmd_decoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ddr3_mem_cmd_decoder.sv
// Memory-side DDR3 command decoder: tracks per-bank state and tRCD/tRP
// timing, flags illegal commands and emits CL/CWL-delayed column strobes.
module ddr3_mem_cmd_decoder #(
  parameter int NUM_BANKS = 8,
  parameter int ROW_W     = 15,
  parameter int COL_W     = 10,
  parameter int CL        = 5,
  parameter int CWL       = 5,
  parameter int TRCD      = 5,
  parameter int TRP       = 5
) (
  input  logic                         cpu_clk,
  input  logic                         reset,
  input  logic                         CS_N,
  input  logic                         RAS_N,
  input  logic                         CAS_N,
  input  logic                         WE_N,
  input  logic [$clog2(NUM_BANKS)-1:0] BA,
  input  logic [ROW_W-1:0]             A,
  output logic                         rd_stb,
  output logic                         wr_stb,
  output logic [$clog2(NUM_BANKS)-1:0] stb_bank,
  output logic [ROW_W-1:0]             stb_row,
  output logic [COL_W-1:0]             stb_col,
  output logic [NUM_BANKS-1:0]         bank_open,
  output logic                         viol,
  output logic [2:0]                   viol_code,
  output logic [15:0]                  ref_cnt
);

  localparam int BW   = $clog2(NUM_BANKS);
  localparam int EW   = BW + ROW_W + COL_W;
  localparam int TMAX = (TRCD > TRP) ? TRCD : TRP;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {
    ST_IDLE, ST_ACTIVATING, ST_ACTIVE, ST_PRECHARGING
  } bank_state_t;

  typedef enum logic [2:0] {
    CMD_MRS, CMD_REF, CMD_PRE, CMD_ACT, CMD_WR, CMD_RD, CMD_ZQ, CMD_NOP
  } cmd_t;

  typedef enum logic [2:0] {
    V_NONE = 3'd0, V_ACT = 3'd1, V_ACCESS = 3'd2, V_PRE = 3'd3,
    V_REF = 3'd4, V_COLLIDE = 3'd5
  } viol_t;

  bank_state_t      state_q [NUM_BANKS];
  bank_state_t      state_nx[NUM_BANKS];
  logic [TW-1:0]    tmr_q   [NUM_BANKS];
  logic [TW-1:0]    tmr_nx  [NUM_BANKS];
  logic [ROW_W-1:0] row_q   [NUM_BANKS];
  logic [ROW_W-1:0] row_nx  [NUM_BANKS];

  cmd_t          cmd;
  logic          cmd_viol;
  viol_t         cmd_code;
  logic          rd_push;
  logic          wr_push;
  logic          ref_ok;
  logic          any_activating;
  logic          all_idle;
  logic [EW-1:0] push_entry;

  logic [CL-1:0]  rd_v;
  logic [EW-1:0]  rd_d [CL];
  logic [CWL-1:0] wr_v;
  logic [EW-1:0]  wr_d [CWL];

  // Command decode; a deselected device behaves like NOP.
  always_comb begin
    cmd = CS_N ? CMD_NOP : cmd_t'({RAS_N, CAS_N, WE_N});
  end

  // Legality check of the sampled command against current bank state.
  always_comb begin
    cmd_viol       = 1'b0;
    cmd_code       = V_NONE;
    rd_push        = 1'b0;
    wr_push        = 1'b0;
    ref_ok         = 1'b0;
    any_activating = 1'b0;
    all_idle       = 1'b1;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (state_q[b] == ST_ACTIVATING) any_activating = 1'b1;
      if (state_q[b] != ST_IDLE)       all_idle       = 1'b0;
    end
    push_entry = {BA, row_q[BA], A[COL_W-1:0]};
    case (cmd)
      CMD_ACT: begin
        if (state_q[BA] != ST_IDLE) begin
          cmd_viol = 1'b1;
          cmd_code = V_ACT;
        end
      end
      CMD_RD, CMD_WR: begin
        if (state_q[BA] != ST_ACTIVE) begin
          cmd_viol = 1'b1;
          cmd_code = V_ACCESS;
        end else if (cmd == CMD_RD) begin
          rd_push = 1'b1;
        end else begin
          wr_push = 1'b1;
        end
      end
      CMD_PRE: begin
        if (A[10] ? any_activating : (state_q[BA] == ST_ACTIVATING)) begin
          cmd_viol = 1'b1;
          cmd_code = V_PRE;
        end
      end
      CMD_REF: begin
        if (!all_idle) begin
          cmd_viol = 1'b1;
          cmd_code = V_REF;
        end else begin
          ref_ok = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Per-bank next state: timers advance, then a legal command applies.
  // The state flips when the timer would reach 0, so the access at
  // exactly ACT+TRCD (or PRE+TRP) already sees the new state.
  always_comb begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      state_nx[b] = state_q[b];
      tmr_nx[b]   = tmr_q[b];
      row_nx[b]   = row_q[b];
      case (state_q[b])
        ST_ACTIVATING: begin
          if (tmr_q[b] <= TW'(1)) begin
            state_nx[b] = ST_ACTIVE;
            tmr_nx[b]   = '0;
          end else begin
            tmr_nx[b] = tmr_q[b] - TW'(1);
          end
        end
        ST_PRECHARGING: begin
          if (tmr_q[b] <= TW'(1)) begin
            state_nx[b] = ST_IDLE;
            tmr_nx[b]   = '0;
          end else begin
            tmr_nx[b] = tmr_q[b] - TW'(1);
          end
        end
        default: ;
      endcase
      if (!cmd_viol) begin
        if (cmd == CMD_ACT && BA == BW'(b)) begin
          row_nx[b]   = A;
          state_nx[b] = (TRCD == 1) ? ST_ACTIVE : ST_ACTIVATING;
          tmr_nx[b]   = TW'(TRCD - 1);
        end else if (state_q[b] == ST_ACTIVE &&
                     ((cmd == CMD_PRE && (A[10] || BA == BW'(b))) ||
                      ((cmd == CMD_RD || cmd == CMD_WR) && A[10] && BA == BW'(b)))) begin
          state_nx[b] = (TRP == 1) ? ST_IDLE : ST_PRECHARGING;
          tmr_nx[b]   = TW'(TRP - 1);
        end
      end
    end
  end

  // Bank state, timer and open-row registers.
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        state_q[b] <= ST_IDLE;
        tmr_q[b]   <= '0;
        row_q[b]   <= '0;
      end
    end else begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        state_q[b] <= state_nx[b];
        tmr_q[b]   <= tmr_nx[b];
        row_q[b]   <= row_nx[b];
      end
    end
  end

  // Open-bank map decoded straight from the bank state flops.
  always_comb begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      bank_open[b] = (state_q[b] == ST_ACTIVE);
    end
  end

  // Read and write latency shift pipelines.
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      rd_v <= '0;
      wr_v <= '0;
      for (int unsigned i = 0; i < CL; i++)  rd_d[i] <= '0;
      for (int unsigned i = 0; i < CWL; i++) wr_d[i] <= '0;
    end else begin
      rd_v[0] <= rd_push;
      rd_d[0] <= push_entry;
      for (int unsigned i = 1; i < CL; i++) begin
        rd_v[i] <= rd_v[i-1];
        rd_d[i] <= rd_d[i-1];
      end
      wr_v[0] <= wr_push;
      wr_d[0] <= push_entry;
      for (int unsigned i = 1; i < CWL; i++) begin
        wr_v[i] <= wr_v[i-1];
        wr_d[i] <= wr_d[i-1];
      end
    end
  end

  // Registered strobes, violation report and refresh counter.
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      rd_stb    <= 1'b0;
      wr_stb    <= 1'b0;
      stb_bank  <= '0;
      stb_row   <= '0;
      stb_col   <= '0;
      viol      <= 1'b0;
      viol_code <= '0;
      ref_cnt   <= '0;
    end else begin
      rd_stb <= rd_v[CL-1];
      wr_stb <= wr_v[CWL-1];
      if (rd_v[CL-1]) begin
        {stb_bank, stb_row, stb_col} <= rd_d[CL-1];
      end else if (wr_v[CWL-1]) begin
        {stb_bank, stb_row, stb_col} <= wr_d[CWL-1];
      end else begin
        {stb_bank, stb_row, stb_col} <= '0;
      end
      viol <= cmd_viol || (rd_v[CL-1] && wr_v[CWL-1]);
      if (cmd_viol) begin
        viol_code <= cmd_code;
      end else if (rd_v[CL-1] && wr_v[CWL-1]) begin
        viol_code <= V_COLLIDE;
      end else begin
        viol_code <= V_NONE;
      end
      if (ref_ok && ref_cnt != '1) ref_cnt <= ref_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ddr3_mem_cmd_decoder.sv
// Directed-vector bench for ddr3_mem_cmd_decoder with default parameters
// (8 banks, CL=CWL=TRCD=TRP=5).
module tb_ddr3_mem_cmd_decoder;

  logic        cpu_clk = 1'b0;
  logic        reset;
  logic        CS_N, RAS_N, CAS_N, WE_N;
  logic [2:0]  BA;
  logic [14:0] A;
  logic        rd_stb, wr_stb;
  logic [2:0]  stb_bank;
  logic [14:0] stb_row;
  logic [9:0]  stb_col;
  logic [7:0]  bank_open;
  logic        viol;
  logic [2:0]  viol_code;
  logic [15:0] ref_cnt;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  localparam logic [3:0] C_REF = 4'b0001, C_PRE = 4'b0010, C_ACT = 4'b0011,
                         C_WR  = 4'b0100, C_RD  = 4'b0101, C_NOP = 4'b0111;

  ddr3_mem_cmd_decoder #(
    .NUM_BANKS(8), .ROW_W(15), .COL_W(10),
    .CL(5), .CWL(5), .TRCD(5), .TRP(5)
  ) dut (
    .cpu_clk(cpu_clk), .reset(reset),
    .CS_N(CS_N), .RAS_N(RAS_N), .CAS_N(CAS_N), .WE_N(WE_N),
    .BA(BA), .A(A),
    .rd_stb(rd_stb), .wr_stb(wr_stb),
    .stb_bank(stb_bank), .stb_row(stb_row), .stb_col(stb_col),
    .bank_open(bank_open), .viol(viol), .viol_code(viol_code),
    .ref_cnt(ref_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one command for one edge; returns 1ns after the sampling edge.
  task automatic issue(input logic [3:0] c, input logic [2:0] ba, input logic [14:0] a);
    {CS_N, RAS_N, CAS_N, WE_N} = c;
    BA = ba;
    A  = a;
    @(posedge cpu_clk);
    #1;
    {CS_N, RAS_N, CAS_N, WE_N} = C_NOP;
    BA = '0;
    A  = '0;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) issue(C_NOP, 3'd0, 15'd0);
  endtask

  initial begin
    {CS_N, RAS_N, CAS_N, WE_N} = 4'b1111;
    BA = '0;
    A  = '0;
    reset = 1'b1;
    repeat (2) @(posedge cpu_clk);
    #1;
    check("rst_rd_stb", {31'd0, rd_stb}, 32'd0);
    check("rst_bank_open", {24'd0, bank_open}, 32'd0);
    check("rst_viol", {31'd0, viol}, 32'd0);
    check("rst_ref_cnt", {16'd0, ref_cnt}, 32'd0);
    reset = 1'b0;

    // ACT bank 2, RD exactly TRCD later
    issue(C_ACT, 3'd2, 15'h1234);
    check("act2_open_pending", {24'd0, bank_open}, 32'h00);
    check("act2_viol", {31'd0, viol}, 32'd0);
    nop(4);
    check("act2_open", {24'd0, bank_open}, 32'h04);
    issue(C_RD, 3'd2, 15'h0040);
    check("rd2_viol", {31'd0, viol}, 32'd0);
    nop(4);
    check("rd2_early", {31'd0, rd_stb}, 32'd0);
    nop(1);
    check("rd2_stb", {31'd0, rd_stb}, 32'd1);
    check("rd2_bank", {29'd0, stb_bank}, 32'd2);
    check("rd2_row", {17'd0, stb_row}, 32'h1234);
    check("rd2_col", {22'd0, stb_col}, 32'h040);
    check("rd2_nov", {31'd0, viol}, 32'd0);
    nop(1);
    check("rd2_one_cycle", {31'd0, rd_stb}, 32'd0);

    // tRCD violation then retry
    issue(C_ACT, 3'd1, 15'h0111);
    nop(3);
    issue(C_RD, 3'd1, 15'h0007);
    check("trcd_viol", {31'd0, viol}, 32'd1);
    check("trcd_code", {29'd0, viol_code}, 32'd2);
    issue(C_RD, 3'd1, 15'h0008);
    check("trcd_retry_ok", {31'd0, viol}, 32'd0);
    nop(4);
    check("trcd_dropped_no_stb", {31'd0, rd_stb}, 32'd0);
    nop(1);
    check("trcd_retry_stb", {31'd0, rd_stb}, 32'd1);
    check("trcd_retry_col", {22'd0, stb_col}, 32'h008);
    check("trcd_retry_row", {17'd0, stb_row}, 32'h0111);

    // Banks 0 and 5 open alongside 1 and 2, then precharge-all
    issue(C_ACT, 3'd0, 15'h0100);
    issue(C_ACT, 3'd5, 15'h0500);
    nop(4);
    check("open_0125", {24'd0, bank_open}, 32'h27);
    issue(C_PRE, 3'd3, 15'h0400);
    check("pre_all_open", {24'd0, bank_open}, 32'h00);
    check("pre_all_viol", {31'd0, viol}, 32'd0);
    nop(3);
    issue(C_ACT, 3'd5, 15'h0555);
    check("trp_early_viol", {31'd0, viol}, 32'd1);
    check("trp_early_code", {29'd0, viol_code}, 32'd1);
    issue(C_ACT, 3'd5, 15'h0555);
    check("trp_ok", {31'd0, viol}, 32'd0);
    issue(C_PRE, 3'd5, 15'h0000);
    check("pre_activating_code", {29'd0, viol_code}, 32'd3);
    nop(3);
    check("bank5_open", {24'd0, bank_open}, 32'h20);

    // Close bank 5, auto-precharge write on bank 3, REF timing
    issue(C_PRE, 3'd5, 15'h0000);
    nop(4);
    issue(C_ACT, 3'd3, 15'h0ABC);
    nop(4);
    check("bank3_open", {24'd0, bank_open}, 32'h08);
    issue(C_WR, 3'd3, 15'h0455);
    check("wrap_closed", {24'd0, bank_open}, 32'h00);
    check("wrap_viol", {31'd0, viol}, 32'd0);
    issue(C_REF, 3'd0, 15'h0000);
    check("ref_early_viol", {31'd0, viol}, 32'd1);
    check("ref_early_code", {29'd0, viol_code}, 32'd4);
    check("ref_early_cnt", {16'd0, ref_cnt}, 32'd0);
    nop(3);
    check("wr_early", {31'd0, wr_stb}, 32'd0);
    nop(1);
    check("wr_stb", {31'd0, wr_stb}, 32'd1);
    check("wr_bank", {29'd0, stb_bank}, 32'd3);
    check("wr_row", {17'd0, stb_row}, 32'h0ABC);
    check("wr_col", {22'd0, stb_col}, 32'h055);
    check("wr_no_rd", {31'd0, rd_stb}, 32'd0);
    issue(C_REF, 3'd0, 15'h0000);
    check("ref_ok_viol", {31'd0, viol}, 32'd0);
    check("ref_cnt_1", {16'd0, ref_cnt}, 32'd1);

    // Back-to-back reads
    issue(C_ACT, 3'd4, 15'h0777);
    nop(4);
    for (int i = 0; i < 4; i++) issue(C_RD, 3'd4, 15'(i));
    nop(1);
    check("b2b_before", {31'd0, rd_stb}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      nop(1);
      check("b2b_stb", {31'd0, rd_stb}, 32'd1);
      check("b2b_col", {22'd0, stb_col}, 32'(i));
    end
    nop(1);
    check("b2b_after", {31'd0, rd_stb}, 32'd0);

    // Reset while a read is in flight
    issue(C_RD, 3'd4, 15'h0010);
    nop(4);
    #2;
    reset = 1'b1;
    #1;
    check("arst_rd_stb", {31'd0, rd_stb}, 32'd0);
    check("arst_open", {24'd0, bank_open}, 32'h00);
    check("arst_ref_cnt", {16'd0, ref_cnt}, 32'd0);
    check("arst_fields", {stb_bank, stb_row, stb_col, viol, viol_code}, 32'd0);
    @(negedge cpu_clk);
    reset = 1'b0;
    @(posedge cpu_clk);
    #1;
    check("arst_lost_stb", {31'd0, rd_stb}, 32'd0);
    nop(2);
    check("arst_lost_stb2", {31'd0, rd_stb}, 32'd0);
    issue(C_RD, 3'd4, 15'h0000);
    check("post_rst_rd_viol", {31'd0, viol}, 32'd1);
    check("post_rst_rd_code", {29'd0, viol_code}, 32'd2);
    nop(1);
    check("viol_one_cycle", {31'd0, viol}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
